// File: rtl/me_lsu.sv
// ME-stage load/store unit: registers one access, holds it on the data bus until completion,
// builds lane strobes/store shifts, extends load data, and reports misalignment and bus faults.
module me_lsu #(
    parameter int XLEN        = 64,
    parameter bit ALIGNED_BUS = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                me_mem_rena,
    input  logic                me_mem_wena,
    input  logic [2:0]          me_funct3,
    input  logic [XLEN-1:0]     me_addr,
    input  logic [XLEN-1:0]     me_wdata,
    input  logic                me_stall_ext,
    input  logic                flush,
    output logic                mem_valid,
    output logic                mem_req,
    output logic [1:0]          mem_size,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_ready,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic [1:0]          mem_resp,
    output logic [XLEN-1:0]     ld_data,
    output logic                ld_valid,
    output logic                stall_req,
    output logic                exc_ld_misal,
    output logic                exc_st_misal,
    output logic                exc_acc_fault,
    output logic [XLEN-1:0]     exc_tval
);

    localparam int SW = XLEN / 8;
    localparam int OW = $clog2(SW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic              req_r;
    logic [1:0]        size_r;
    logic              uns_r;
    logic [XLEN-1:0]   addr_r;
    logic [XLEN-1:0]   mem_addr_r;
    logic [XLEN-1:0]   wdata_r;
    logic [SW-1:0]     strb_r;
    logic [XLEN-1:0]   ld_data_r;
    logic [1:0]        resp_r;
    logic              acc_s;
    logic              mis_s;
    logic [OW-1:0]     off_s;

    function automatic logic misaligned(input logic [1:0] size, input logic [OW-1:0] off);
        logic [2:0] off3;
        logic [2:0] mask;
        off3 = 3'(off);
        case (size)
            2'd0:    mask = 3'b000;
            2'd1:    mask = 3'b001;
            2'd2:    mask = 3'b011;
            2'd3:    mask = 3'b111;
            default: mask = 3'b111;
        endcase
        // A doubleword cannot be carried by a 32-bit bus at all.
        return (|(off3 & mask)) || ((size == 2'd3) && (XLEN == 32));
    endfunction

    function automatic logic [SW-1:0] lane_strobe(input logic [1:0] size, input logic [OW-1:0] off);
        logic [3:0]    nbytes;
        logic [SW-1:0] base;
        nbytes = 4'd1 << size;
        base   = ({{(SW-1){1'b0}}, 1'b1} << nbytes) - {{(SW-1){1'b0}}, 1'b1};
        return base << off;
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata, input logic [1:0] size,
                                                    input logic uns, input logic [OW-1:0] off);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] mask;
        logic [6:0]      nbits;
        logic            sgn;
        sh    = ALIGNED_BUS ? (rdata >> {off, 3'b000}) : rdata;
        nbits = 7'd8 << size;
        // Shifting by the full width yields zero, so a full-width access gets an all-ones mask.
        mask  = ~({XLEN{1'b1}} << nbits);
        case (size)
            2'd0:    sgn = sh[7];
            2'd1:    sgn = sh[15];
            2'd2:    sgn = sh[31];
            2'd3:    sgn = sh[XLEN-1];
            default: sgn = 1'b0;
        endcase
        return (sh & mask) | ((sgn && !uns) ? ~mask : {XLEN{1'b0}});
    endfunction

    assign acc_s = (me_mem_rena | me_mem_wena) & ~flush;
    assign off_s = me_addr[OW-1:0];
    assign mis_s = misaligned(me_funct3[1:0], off_s);

    assign mem_req   = req_r;
    assign mem_size  = size_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = wdata_r;
    assign mem_wstrb = strb_r;
    assign ld_data   = ld_data_r;

    // Next-state and per-state control outputs.
    always_comb begin
        state_s       = state_r;
        mem_valid     = 1'b0;
        stall_req     = 1'b0;
        ld_valid      = 1'b0;
        exc_ld_misal  = 1'b0;
        exc_st_misal  = 1'b0;
        exc_acc_fault = 1'b0;
        exc_tval      = {XLEN{1'b0}};
        case (state_r)
            IDLE: begin
                if (acc_s && mis_s) begin
                    exc_ld_misal = me_mem_rena;
                    exc_st_misal = me_mem_wena;
                    exc_tval     = me_addr;
                end else if (acc_s) begin
                    stall_req = 1'b1;
                    state_s   = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                mem_valid = 1'b1;
                stall_req = 1'b1;
                if (mem_ready) begin
                    state_s = flush ? IDLE : DONE;
                end else if (flush) begin
                    state_s = DRAIN;
                end else begin
                    state_s = BUSY;
                end
            end
            DRAIN: begin
                mem_valid = 1'b1;
                stall_req = acc_s;
                if (mem_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE: begin
                ld_valid = ~req_r && (resp_r == 2'b00);
                if (resp_r != 2'b00) begin
                    exc_acc_fault = 1'b1;
                    exc_tval      = addr_r;
                end else begin
                    exc_acc_fault = 1'b0;
                end
                if (me_stall_ext && !flush) begin
                    state_s = DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, access capture on IDLE->BUSY, and load result capture on completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            req_r      <= 1'b0;
            size_r     <= 2'd0;
            uns_r      <= 1'b0;
            addr_r     <= {XLEN{1'b0}};
            mem_addr_r <= {XLEN{1'b0}};
            wdata_r    <= {XLEN{1'b0}};
            strb_r     <= {SW{1'b0}};
            ld_data_r  <= {XLEN{1'b0}};
            resp_r     <= 2'b00;
        end else begin
            state_r <= state_s;
            if (state_r == IDLE && state_s == BUSY) begin
                req_r      <= me_mem_wena;
                size_r     <= me_funct3[1:0];
                uns_r      <= me_funct3[2];
                addr_r     <= me_addr;
                mem_addr_r <= ALIGNED_BUS ? {me_addr[XLEN-1:OW], {OW{1'b0}}} : me_addr;
                wdata_r    <= ALIGNED_BUS ? (me_wdata << {off_s, 3'b000}) : me_wdata;
                strb_r     <= lane_strobe(me_funct3[1:0], off_s);
            end
            if (state_r == BUSY && mem_ready) begin
                ld_data_r <= load_extend(mem_rdata, size_r, uns_r, addr_r[OW-1:0]);
                resp_r    <= mem_resp;
            end
        end
    end

endmodule

// File: tb/tb_me_lsu.sv
// Bench for me_lsu: vector table of single accesses scored through an expected-result queue,
// plus hand-written flush, DONE-hold, reset and 32-bit sequences.
module tb_me_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        me_mem_rena, me_mem_wena, me_stall_ext, flush;
    logic [2:0]  me_funct3;
    logic [63:0] me_addr, me_wdata;
    logic        mem_valid, mem_req, mem_ready;
    logic [1:0]  mem_size, mem_resp;
    logic [63:0] mem_addr, mem_wdata, mem_rdata, ld_data, exc_tval;
    logic [7:0]  mem_wstrb;
    logic        ld_valid, stall_req, exc_ld_misal, exc_st_misal, exc_acc_fault;

    logic        d_rena, d_wena, d_ready;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr, d_rdata;
    logic        d_valid, d_req, d_ld_valid, d_stall, d_ld_mis, d_st_mis, d_fault;
    logic [1:0]  d_size;
    logic [31:0] d_maddr, d_mwdata, d_ld_data, d_tval;
    logic [3:0]  d_wstrb;

    me_lsu #(.XLEN(64), .ALIGNED_BUS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .me_mem_rena(me_mem_rena), .me_mem_wena(me_mem_wena),
        .me_funct3(me_funct3), .me_addr(me_addr), .me_wdata(me_wdata), .me_stall_ext(me_stall_ext),
        .flush(flush), .mem_valid(mem_valid), .mem_req(mem_req), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .ld_data(ld_data), .ld_valid(ld_valid),
        .stall_req(stall_req), .exc_ld_misal(exc_ld_misal), .exc_st_misal(exc_st_misal),
        .exc_acc_fault(exc_acc_fault), .exc_tval(exc_tval)
    );

    me_lsu #(.XLEN(32), .ALIGNED_BUS(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .me_mem_rena(d_rena), .me_mem_wena(d_wena),
        .me_funct3(d_funct3), .me_addr(d_addr), .me_wdata(32'h0), .me_stall_ext(1'b0),
        .flush(1'b0), .mem_valid(d_valid), .mem_req(d_req), .mem_size(d_size),
        .mem_addr(d_maddr), .mem_wdata(d_mwdata), .mem_wstrb(d_wstrb), .mem_ready(d_ready),
        .mem_rdata(d_rdata), .mem_resp(2'b00), .ld_data(d_ld_data), .ld_valid(d_ld_valid),
        .stall_req(d_stall), .exc_ld_misal(d_ld_mis), .exc_st_misal(d_st_mis),
        .exc_acc_fault(d_fault), .exc_tval(d_tval)
    );

    typedef struct {
        logic        rena;
        logic        wena;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [1:0]  resp;
        int          delay;
        logic        mis;
        logic [7:0]  strb;
        logic [63:0] maddr;
        logic [63:0] mwdata;
        logic [63:0] ld;
        logic        ldv;
        logic        fault;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic rena, input logic wena, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                                input logic [1:0] resp, input int delay, input logic mis, input logic [7:0] strb,
                                input logic [63:0] maddr, input logic [63:0] mwdata, input logic [63:0] ld,
                                input logic ldv, input logic fault);
        vec_t v;
        v.rena = rena; v.wena = wena; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.resp = resp; v.delay = delay; v.mis = mis; v.strb = strb; v.maddr = maddr; v.mwdata = mwdata;
        v.ld = ld; v.ldv = ldv; v.fault = fault;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        me_mem_rena = 1'b0; me_mem_wena = 1'b0; me_funct3 = 3'd0; me_addr = 64'h0; me_wdata = 64'h0;
        me_stall_ext = 1'b0; flush = 1'b0; mem_ready = 1'b0; mem_rdata = 64'h0; mem_resp = 2'b00;
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int   stalls;
        @(negedge clk);
        me_mem_rena = v.rena; me_mem_wena = v.wena; me_funct3 = v.f3; me_addr = v.addr; me_wdata = v.wdata;
        #1;
        if (v.mis) begin
            check("mis_ld_flag", exc_ld_misal, v.rena);
            check("mis_st_flag", exc_st_misal, v.wena);
            check("mis_tval", exc_tval, v.addr);
            check("mis_stall", stall_req, 0);
            @(negedge clk);
            me_mem_rena = 1'b0; me_mem_wena = 1'b0;
            #1;
            check("mis_no_bus", mem_valid, 0);
            return;
        end
        sb.push_back(v);
        stalls = stall_req ? 1 : 0;
        for (int c = 1; c <= v.delay; c++) begin
            @(negedge clk);
            if (c == v.delay) begin
                mem_ready = 1'b1; mem_rdata = v.rdata; mem_resp = v.resp;
            end
            #1;
            if (stall_req) stalls++;
            check("busy_valid", mem_valid, 1);
            check("busy_addr", mem_addr, sb[0].maddr);
            check("busy_strb", mem_wstrb, sb[0].strb);
            check("busy_wdata", mem_wdata, sb[0].mwdata);
            check("busy_req", mem_req, sb[0].wena);
            check("busy_size", mem_size, sb[0].f3[1:0]);
        end
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = 64'h0; mem_resp = 2'b00; me_mem_rena = 1'b0; me_mem_wena = 1'b0;
        #1;
        e = sb.pop_front();
        check("done_ld_valid", ld_valid, e.ldv);
        if (e.ldv) check("done_ld_data", ld_data, e.ld);
        check("done_fault", exc_acc_fault, e.fault);
        if (e.fault) check("done_tval", exc_tval, e.addr);
        check("done_stall", stall_req, 0);
        check("stall_cycles", stalls, e.delay + 1);
    endtask

    initial begin
        vecs.push_back(mk(1, 0, 3'b010, 64'h1004, 64'h0, 64'h8000_0000_0000_0000, 2'b00, 3, 0, 8'hF0, 64'h1000, 64'h0, 64'hFFFF_FFFF_8000_0000, 1, 0));
        vecs.push_back(mk(0, 1, 3'b000, 64'h2003, 64'hAB, 64'h0, 2'b00, 2, 0, 8'h08, 64'h2000, 64'h0000_0000_AB00_0000, 64'h0, 0, 0));
        vecs.push_back(mk(1, 0, 3'b100, 64'h4005, 64'h0, 64'h0000_9A00_0000_0000, 2'b10, 1, 0, 8'h20, 64'h4000, 64'h0, 64'h0, 0, 1));
        vecs.push_back(mk(1, 0, 3'b001, 64'h5006, 64'h0, 64'h8001_0000_0000_0000, 2'b00, 1, 0, 8'hC0, 64'h5000, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1, 0));
        vecs.push_back(mk(1, 0, 3'b101, 64'h5002, 64'h0, 64'h0000_0000_F00D_0000, 2'b00, 1, 0, 8'h0C, 64'h5000, 64'h0, 64'h0000_0000_0000_F00D, 1, 0));
        vecs.push_back(mk(1, 0, 3'b011, 64'h6000, 64'h0, 64'h1234_5678_9ABC_DEF0, 2'b00, 2, 0, 8'hFF, 64'h6000, 64'h0, 64'h1234_5678_9ABC_DEF0, 1, 0));
        vecs.push_back(mk(0, 1, 3'b011, 64'h7008, 64'hDEAD_BEEF_0123_4567, 64'h0, 2'b00, 1, 0, 8'hFF, 64'h7008, 64'hDEAD_BEEF_0123_4567, 64'h0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b001, 64'h7006, 64'hFFFF_1234, 64'h0, 2'b00, 1, 0, 8'hC0, 64'h7000, 64'h1234_0000_0000_0000, 64'h0, 0, 0));
        vecs.push_back(mk(1, 0, 3'b000, 64'h8007, 64'h0, 64'h7F00_0000_0000_0000, 2'b00, 1, 0, 8'h80, 64'h8000, 64'h0, 64'h7F, 1, 0));
        vecs.push_back(mk(1, 0, 3'b010, 64'h9000, 64'h0, 64'h1, 2'b01, 1, 0, 8'h0F, 64'h9000, 64'h0, 64'h0, 0, 1));
        vecs.push_back(mk(0, 1, 3'b010, 64'h9004, 64'h1122_3344, 64'h0, 2'b00, 2, 0, 8'hF0, 64'h9000, 64'h1122_3344_0000_0000, 64'h0, 0, 0));
        vecs.push_back(mk(1, 0, 3'b000, 64'h8001, 64'h0, 64'h0000_0000_0000_8000, 2'b00, 1, 0, 8'h02, 64'h8000, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1, 0));
        vecs.push_back(mk(1, 0, 3'b110, 64'h8004, 64'h0, 64'h8765_4321_0000_0000, 2'b00, 1, 0, 8'hF0, 64'h8000, 64'h0, 64'h0000_0000_8765_4321, 1, 0));
        vecs.push_back(mk(1, 0, 3'b001, 64'h3001, 64'h0, 64'h0, 2'b00, 0, 1, 8'h00, 64'h0, 64'h0, 64'h0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b010, 64'h3002, 64'h0, 64'h0, 2'b00, 0, 1, 8'h00, 64'h0, 64'h0, 64'h0, 0, 0));
        vecs.push_back(mk(1, 0, 3'b011, 64'h3004, 64'h0, 64'h0, 2'b00, 0, 1, 8'h00, 64'h0, 64'h0, 64'h0, 0, 0));

        idle_inputs();
        d_rena = 1'b0; d_wena = 1'b0; d_funct3 = 3'd0; d_addr = 32'h0; d_ready = 1'b0; d_rdata = 32'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ctl", {mem_valid, mem_req, mem_size, stall_req, ld_valid, exc_ld_misal, exc_st_misal, exc_acc_fault}, 0);
        check("rst_data", mem_addr | mem_wdata | ld_data | exc_tval | {56'h0, mem_wstrb}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Flush in the second BUSY cycle: the bus access must drain, with a new load waiting behind it.
        @(negedge clk); me_mem_rena = 1'b1; me_funct3 = 3'b011; me_addr = 64'hA000; #1;
        check("fl_idle_stall", stall_req, 1);
        @(negedge clk); #1;
        check("fl_busy1_valid", mem_valid, 1);
        @(negedge clk); flush = 1'b1; #1;
        check("fl_busy2_valid", mem_valid, 1);
        @(negedge clk); flush = 1'b0; me_mem_rena = 1'b0; #1;
        check("fl_drain_valid", mem_valid, 1);
        check("fl_drain_stall0", stall_req, 0);
        check("fl_drain_addr", mem_addr, 64'hA000);
        @(negedge clk); me_mem_rena = 1'b1; me_addr = 64'hB008; #1;
        check("fl_drain_stall1", stall_req, 1);
        check("fl_drain_hold", mem_addr, 64'hA000);
        @(negedge clk); mem_ready = 1'b1; mem_resp = 2'b10; mem_rdata = 64'hFFFF; #1;
        check("fl_c5_valid", mem_valid, 1);
        @(negedge clk); mem_ready = 1'b0; mem_resp = 2'b00; #1;
        check("fl_no_ldv", ld_valid, 0);
        check("fl_no_fault", exc_acc_fault, 0);
        check("fl_idle_novalid", mem_valid, 0);
        check("fl_new_stall", stall_req, 1);
        @(negedge clk); mem_ready = 1'b1; mem_rdata = 64'h0102_0304_0506_0708; #1;
        check("fl_new_addr", mem_addr, 64'hB008);
        @(negedge clk); mem_ready = 1'b0; mem_rdata = 64'h0; me_mem_rena = 1'b0; #1;
        check("fl_new_ldv", ld_valid, 1);
        check("fl_new_data", ld_data, 64'h0102_0304_0506_0708);

        // Flush coinciding with ready discards the result.
        @(negedge clk); me_mem_rena = 1'b1; me_funct3 = 3'b010; me_addr = 64'hD000; #1;
        @(negedge clk); flush = 1'b1; mem_ready = 1'b1; mem_rdata = 64'hFFFF_FFFF; #1;
        check("fr_valid", mem_valid, 1);
        @(negedge clk); flush = 1'b0; mem_ready = 1'b0; mem_rdata = 64'h0; me_mem_rena = 1'b0; #1;
        check("fr_no_ldv", ld_valid, 0);
        check("fr_idle", mem_valid | stall_req, 0);

        // Bus error on lbu held in DONE for three cycles by a later-stage stall.
        @(negedge clk); me_mem_rena = 1'b1; me_funct3 = 3'b100; me_addr = 64'hC001; #1;
        @(negedge clk); mem_ready = 1'b1; mem_resp = 2'b10; #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); mem_ready = 1'b0; mem_resp = 2'b00; me_stall_ext = (k < 2); me_mem_rena = (k < 2); #1;
            check("hold_fault", exc_acc_fault, 1);
            check("hold_tval", exc_tval, 64'hC001);
            check("hold_ldv", ld_valid, 0);
            check("hold_stall", stall_req, 0);
        end
        @(negedge clk); me_stall_ext = 1'b0; #1;
        check("hold_release", exc_acc_fault, 0);

        // Reset asserted mid-BUSY.
        @(negedge clk); me_mem_rena = 1'b1; me_funct3 = 3'b011; me_addr = 64'hE000; #1;
        @(negedge clk); #1;
        check("rb_busy", mem_valid, 1);
        @(negedge clk); rst_n = 1'b0; me_mem_rena = 1'b0; #1;
        @(negedge clk); #1;
        check("rb_ctl", {mem_valid, mem_size, stall_req, ld_valid, exc_acc_fault}, 0);
        check("rb_data", mem_addr | {56'h0, mem_wstrb}, 0);
        @(negedge clk); rst_n = 1'b1;

        // 32-bit instance: doubleword is always misaligned; lh at offset 2.
        @(negedge clk); d_rena = 1'b1; d_funct3 = 3'b011; d_addr = 32'h1000; #1;
        check("x32_ld_mis", d_ld_mis, 1);
        check("x32_tval", d_tval, 32'h1000);
        check("x32_mis_stall", d_stall | d_valid, 0);
        @(negedge clk); d_funct3 = 3'b001; d_addr = 32'h2002; #1;
        check("x32_stall", d_stall, 1);
        @(negedge clk); d_ready = 1'b1; d_rdata = 32'hBEEF_0000; #1;
        check("x32_addr", d_maddr, 32'h2000);
        check("x32_strb", d_wstrb, 4'hC);
        check("x32_size", d_size, 2'd1);
        @(negedge clk); d_ready = 1'b0; d_rena = 1'b0; #1;
        check("x32_ldv", d_ld_valid, 1);
        check("x32_ld", d_ld_data, 32'hFFFF_BEEF);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
